// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

    typedef enum logic {
        FETCH_ISSUE = 1'b0,
        FETCH_HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [2:0]  WORD_BYTES = 3'd4;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: assembles 32-bit words from four byte reads
// on a shared memory port, owns the PC and raises the fetch stall request.
//
// state       | meaning
// ------------+------------------------------------------------
// FETCH_ISSUE | issuing byte reads / collecting responses
// FETCH_HOLD  | word complete, presented until consumed
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic              mem_busy_i,
    input  logic [7:0]        mem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              valid_o,
    output logic              stall_req_o
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [2:0]        issue_cnt, issue_nxt;
    logic [2:0]        rcv_cnt, rcv_nxt;
    logic              pend, pend_nxt;
    logic [23:0]       lanes, lanes_nxt;
    logic [31:0]       inst_q, inst_nxt;
    logic              valid_q, valid_nxt;
    logic              accept;

    assign mem_rd_o    = ~rst && (state == FETCH_ISSUE) && (issue_cnt < WORD_BYTES);
    assign mem_addr_o  = pc + {{(ADDR_W-3){1'b0}}, issue_cnt};
    assign accept      = mem_rd_o && ~mem_busy_i;
    assign pc_o        = pc;
    assign valid_o     = valid_q;
    assign inst_o      = valid_q ? inst_q : ZERO_WORD;
    assign stall_req_o = ~rst && ~valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_ISSUE;
            pc        <= RESET_PC;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            pend      <= 1'b0;
            lanes     <= '0;
            inst_q    <= ZERO_WORD;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            issue_cnt <= issue_nxt;
            rcv_cnt   <= rcv_nxt;
            pend      <= pend_nxt;
            lanes     <= lanes_nxt;
            inst_q    <= inst_nxt;
            valid_q   <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        issue_nxt = issue_cnt;
        rcv_nxt   = rcv_cnt;
        pend_nxt  = pend;
        lanes_nxt = lanes;
        inst_nxt  = inst_q;
        valid_nxt = valid_q;

        if (branch_en_i) begin
            // Clearing pend drops both the in-flight response and any request accepted now.
            pc_nxt    = {branch_target_i[ADDR_W-1:2], 2'b00};
            issue_nxt = '0;
            rcv_nxt   = '0;
            pend_nxt  = 1'b0;
            valid_nxt = 1'b0;
            state_nxt = FETCH_ISSUE;
        end else begin
            case (state)
                FETCH_ISSUE: begin
                    pend_nxt = accept;
                    if (accept) issue_nxt = issue_cnt + 3'd1;
                    if (pend) begin
                        rcv_nxt = rcv_cnt + 3'd1;
                        case (rcv_cnt)
                            3'd0: lanes_nxt[7:0]   = mem_data_i;
                            3'd1: lanes_nxt[15:8]  = mem_data_i;
                            3'd2: lanes_nxt[23:16] = mem_data_i;
                            default: begin
                                inst_nxt  = {mem_data_i, lanes};
                                valid_nxt = 1'b1;
                                state_nxt = FETCH_HOLD;
                            end
                        endcase
                    end
                end
                FETCH_HOLD: begin
                    if (!stall_i) begin
                        pc_nxt    = pc + ADDR_W'(WORD_BYTES);
                        issue_nxt = '0;
                        rcv_nxt   = '0;
                        pend_nxt  = 1'b0;
                        valid_nxt = 1'b0;
                        state_nxt = FETCH_ISSUE;
                    end
                end
                default: state_nxt = FETCH_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a byte-wide memory model
// (byte i = (7*i+3) mod 256, except a known instruction at address 0).
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_en_i;
    logic [31:0] branch_target_i;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic        mem_busy_i;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        stall_req_o;

    int vectors = 0;
    int miscompares = 0;
    int n;

    logic [7:0] mem [0:511];

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_en_i(branch_en_i),
        .branch_target_i(branch_target_i), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
        .mem_busy_i(mem_busy_i), .mem_data_i(mem_data_i), .pc_o(pc_o), .inst_o(inst_o),
        .valid_o(valid_o), .stall_req_o(stall_req_o)
    );

    always @(posedge clk)
        if (mem_rd_o && !mem_busy_i) mem_data_i <= mem[mem_addr_o[8:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!valid_o && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'((i * 7 + 3) & 8'hff);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        mem_data_i = 8'h00;
        rst = 1'b1; stall_i = 1'b0; branch_en_i = 1'b0; branch_target_i = '0; mem_busy_i = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_rd", {31'b0, mem_rd_o}, 32'h0);
        chk("rst_stall_req", {31'b0, stall_req_o}, 32'h0);

        // Reset + fetch: t0 is now
        rst = 1'b0;
        #1;
        chk("t0_rd", {31'b0, mem_rd_o}, 32'h1);
        chk("t0_addr", mem_addr_o, 32'h0);
        chk("t0_stall_req", {31'b0, stall_req_o}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("fetch_stall_req", {31'b0, stall_req_o}, 32'h1);
        end
        tick();
        chk("fetch_valid", {31'b0, valid_o}, 32'h1);
        chk("fetch_pc", pc_o, 32'h0);
        chk("fetch_inst", inst_o, 32'h0000_0513);
        tick();
        chk("next_addr", mem_addr_o, 32'h4);
        chk("next_rd", {31'b0, mem_rd_o}, 32'h1);
        chk("next_inst_bubble", inst_o, 32'h0);

        // Stall hold on the word at 4
        stall_i = 1'b1;
        wait_valid(n);
        chk("stall_latency", n, 32'd5);
        chk("stall_inst", inst_o, 32'h342d_261f);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_pc", pc_o, 32'h4);
            chk("hold_inst", inst_o, 32'h342d_261f);
            chk("hold_rd", {31'b0, mem_rd_o}, 32'h0);
        end
        stall_i = 1'b0;
        tick();
        chk("release_pc", pc_o, 32'h8);
        chk("release_valid", {31'b0, valid_o}, 32'h0);
        chk("release_addr", mem_addr_o, 32'h8);

        // Busy on byte 2 request for 2 cycles (t0 = now)
        tick(); tick();
        chk("busy_addr0", mem_addr_o, 32'ha);
        mem_busy_i = 1'b1;
        tick();
        chk("busy_addr1", mem_addr_o, 32'ha);
        chk("busy_rd", {31'b0, mem_rd_o}, 32'h1);
        tick();
        mem_busy_i = 1'b0;
        chk("busy_retry_addr", mem_addr_o, 32'ha);
        wait_valid(n);
        chk("busy_latency", n, 32'd3);
        chk("busy_inst", inst_o, 32'h5049_423b);
        chk("busy_pc", pc_o, 32'h8);

        // Mid-fetch branch at t0+2 to 0x103
        tick(); tick(); tick();
        chk("br_pre_pc", pc_o, 32'hc);
        branch_en_i = 1'b1; branch_target_i = 32'h103;
        tick();
        branch_en_i = 1'b0;
        chk("br_pc", pc_o, 32'h100);
        chk("br_addr", mem_addr_o, 32'h100);
        chk("br_valid", {31'b0, valid_o}, 32'h0);
        wait_valid(n);
        chk("br_latency", n, 32'd5);
        chk("br_inst", inst_o, 32'h1811_0a03);
        chk("br_word_pc", pc_o, 32'h100);

        // Branch in HOLD to 0x40, then branch vs consume to 0x80
        stall_i = 1'b1; branch_en_i = 1'b1; branch_target_i = 32'h40;
        tick();
        branch_en_i = 1'b0;
        wait_valid(n);
        chk("b40_latency", n, 32'd5);
        chk("b40_pc", pc_o, 32'h40);
        chk("b40_inst", inst_o, 32'hd8d1_cac3);
        stall_i = 1'b0; branch_en_i = 1'b1; branch_target_i = 32'h80;
        tick();
        branch_en_i = 1'b0;
        chk("bvc_pc", pc_o, 32'h80);
        chk("bvc_valid", {31'b0, valid_o}, 32'h0);
        wait_valid(n);
        chk("bvc_latency", n, 32'd5);
        chk("bvc_inst", inst_o, 32'h9891_8a83);

        // Reset mid-fetch at t0+3
        tick();
        chk("pre_rst_pc", pc_o, 32'h84);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst_pc", pc_o, 32'h0);
        chk("mrst_addr", mem_addr_o, 32'h0);
        chk("mrst_inst", inst_o, 32'h0);
        chk("mrst_valid", {31'b0, valid_o}, 32'h0);
        chk("mrst_rd", {31'b0, mem_rd_o}, 32'h0);
        chk("mrst_stall_req", {31'b0, stall_req_o}, 32'h0);
        rst = 1'b0;
        wait_valid(n);
        chk("mrst_latency", n, 32'd5);
        chk("mrst_inst_after", inst_o, 32'h0000_0513);
        chk("mrst_pc_after", pc_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller.
- Sits between the PC/control logic and the IF stage.
- Fetches each 32-bit instruction from the byte-wide, shared instruction memory port as four little-endian byte reads.
- Presents the assembled word with its PC to IF.
- Owns the PC register: sequential increment, branch redirect, and the fetch stall request to the pipeline controller.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  downstream stalled; hold the presented word
- branch_en_i  in  1  redirect request (from EX)
- branch_target_i  in  ADDR_W  redirect address; bits [1:0] ignored (treated as 0)
- mem_addr_o  out  ADDR_W  byte address of current read request
- mem_rd_o  out  1  read request
- mem_busy_i  in  1  port taken by another requester; request not accepted
- mem_data_i  in  8  read data, valid the cycle after an accepted request
- pc_o  out  ADDR_W  PC of the word being fetched or presented
- inst_o  out  32  assembled instruction; 32'h0 when valid_o=0
- valid_o  out  1  inst_o/pc_o hold a complete instruction
- stall_req_o  out  1  fetch not complete; pipeline must bubble

## Operation

**States**
- ISSUE: fetching.
- HOLD: word complete, waiting to be consumed.

**Internal registers**
- pc
- issue_cnt (0..4)
- rcv_cnt (0..4)
- pend (response expected next cycle)
- 32-bit assembly buffer

**ISSUE**
- mem_rd_o = (issue_cnt<4); mem_addr_o = pc + issue_cnt.
- A request is accepted when mem_rd_o=1 and mem_busy_i=0: issue_cnt++, pend<=1. If not accepted, pend<=0 and the same byte is retried.
- When pend=1, mem_data_i is written to buffer[8*rcv_cnt+7 : 8*rcv_cnt] and rcv_cnt++.
- When the 4th byte is captured: state<=HOLD, valid_o<=1, inst_o<=assembled word.

**HOLD**
- mem_rd_o=0.
- If stall_i=0, the word is consumed this cycle:
  - pc<=pc+4, counters<=0, valid_o<=0, state<=ISSUE.
  - The next request issues the following cycle.
- If stall_i=1: everything holds.

**Branch** (branch_en_i=1, any state; priority over consume and capture)
- pc<={branch_target_i[ADDR_W-1:2],2'b00}.
- issue_cnt, rcv_cnt, pend <= 0; valid_o<=0; state<=ISSUE.
- A request accepted in the branch cycle is abandoned: its response is dropped.

**Derived outputs**
- stall_req_o = ~valid_o (0 during rst).
- pc wraps modulo 2^ADDR_W.

## Timing

**Reset values**
- pc_o = mem_addr_o = RESET_PC
- inst_o = 0
- valid_o = 0, mem_rd_o = 0, stall_req_o = 0
- state = ISSUE, all counters and pend cleared

**Reset behaviour**
- rst asserted mid-fetch takes effect at the next edge and discards all partial data.
- First request is in the cycle after rst deasserts (t0).

**Fetch latency with no busy**
- Requests in t0..t0+3; data in t0+1..t0+4.
- valid_o=1 from t0+5: 5 cycles per instruction, plus 1 cycle if consumed immediately (consume edge → next ISSUE).

**Other timing**
- Each busy cycle on an unaccepted request adds exactly 1 cycle.
- After a branch at cycle tb, the first request to the target is at tb+1; valid_o no earlier than tb+6.
- pc_o and inst_o are stable throughout HOLD.

## Structure

- Shared defines header (with existing Defines.vh style constants):
  - state encoding `FetchIssue` / `FetchHold`
  - `WordBytes` = 4
  - `ZeroWord` reused for the inst_o bubble
- Single module; no sub-module warranted. The byte-lane write is a 2-bit indexed part-select in the same always block.

## Test plan

- **Reset + fetch:** memory bytes 13,05,00,00 at 0, no busy, stall_i=0 → stall_req_o=1 for t0..t0+4; at t0+5 valid_o=1, pc_o=0, inst_o=32'h0000_0513; next fetch mem_addr_o=4 at t0+6.
- **Stall hold:** stall_i=1 for 3 cycles while valid_o=1 → pc_o/inst_o unchanged, mem_rd_o=0; consume on release → pc_o=4 next cycle.
- **Busy:** mem_busy_i=1 during the byte-2 request for 2 cycles → byte 2 re-requested at the same address; valid_o at t0+7; word correct.
- **Mid-fetch branch:** branch_en_i=1 at t0+2 with target 32'h103 → pc_o=32'h100, stale bytes dropped; valid_o at t0+8 with the word from 0x100.
- **Branch vs consume:** branch_en_i=1 and stall_i=0 in HOLD at pc 0x40, target 0x80 → pc_o=0x80, not 0x44.
- **Reset mid-fetch:** rst at t0+3 → next cycle all outputs at reset values; the subsequent fetch of RESET_PC completes correctly.
